// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-only bus (AR + R channels) shared by the IFU, LSU and memory sides of the arbiter.
// master drives AR and RREADY; slave drives ARREADY and the R channel.
interface axi_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) ();
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between IFU and LSU, one burst in flight.
// The memory-side ARID carries the owner index; the owner's original ARID is restored on R.
module axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    axi_rd_arbiter_if.slave   ifu_if,
    axi_rd_arbiter_if.slave   lsu_if,
    axi_rd_arbiter_if.master  mem_if,
    output logic              arb_busy_o,
    output logic              arb_err_o
);

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] orig_id_q, orig_id_d;

    // Owner-selected view of the requesting master
    logic              own_arvalid;
    logic [ID_W-1:0]   own_arid;
    logic [ADDR_W-1:0] own_araddr;
    logic [7:0]        own_arlen;
    logic [2:0]        own_arsize;
    logic [1:0]        own_arburst;
    logic              own_rready;

    always_comb begin
        if (owner_q) begin
            own_arvalid = lsu_if.arvalid;
            own_arid    = lsu_if.arid;
            own_araddr  = lsu_if.araddr;
            own_arlen   = lsu_if.arlen;
            own_arsize  = lsu_if.arsize;
            own_arburst = lsu_if.arburst;
            own_rready  = lsu_if.rready;
        end else begin
            own_arvalid = ifu_if.arvalid;
            own_arid    = ifu_if.arid;
            own_araddr  = ifu_if.araddr;
            own_arlen   = ifu_if.arlen;
            own_arsize  = ifu_if.arsize;
            own_arburst = ifu_if.arburst;
            own_rready  = ifu_if.rready;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            orig_id_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            err_q     <= err_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            orig_id_q <= orig_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        err_d     = err_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        orig_id_d = orig_id_q;
        case (state_q)
            StIdle: begin
                // On a tie the master that did not win last time is granted
                if (ifu_if.arvalid && lsu_if.arvalid) begin
                    owner_d = ~last_q;
                    last_d  = ~last_q;
                    state_d = StAr;
                end else if (ifu_if.arvalid) begin
                    owner_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = StAr;
                end else if (lsu_if.arvalid) begin
                    owner_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = StAr;
                end
                if (mem_if.rvalid) err_d = 1'b1;
            end
            StAr: begin
                if (own_arvalid && mem_if.arready) begin
                    len_d     = own_arlen;
                    orig_id_d = own_arid;
                    cnt_d     = '0;
                    state_d   = StR;
                end
                if (mem_if.rvalid) err_d = 1'b1;
            end
            StR: begin
                if (mem_if.rvalid && own_rready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (mem_if.rlast != (cnt_q == len_q)) err_d = 1'b1;
                    if (mem_if.rid[0] != owner_q) err_d = 1'b1;
                    if (mem_if.rlast) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_if.arid    = {{(ID_W-1){1'b0}}, owner_q};
        mem_if.araddr  = own_araddr;
        mem_if.arlen   = own_arlen;
        mem_if.arsize  = own_arsize;
        mem_if.arburst = own_arburst;
        mem_if.arvalid = 1'b0;
        mem_if.rready  = 1'b0;

        ifu_if.arready = 1'b0;
        ifu_if.rid     = orig_id_q;
        ifu_if.rdata   = mem_if.rdata;
        ifu_if.rresp   = mem_if.rresp;
        ifu_if.rlast   = mem_if.rlast;
        ifu_if.rvalid  = 1'b0;

        lsu_if.arready = 1'b0;
        lsu_if.rid     = orig_id_q;
        lsu_if.rdata   = mem_if.rdata;
        lsu_if.rresp   = mem_if.rresp;
        lsu_if.rlast   = mem_if.rlast;
        lsu_if.rvalid  = 1'b0;

        case (state_q)
            StAr: begin
                mem_if.arvalid = own_arvalid;
                if (owner_q) lsu_if.arready = mem_if.arready;
                else         ifu_if.arready = mem_if.arready;
            end
            StR: begin
                mem_if.rready = own_rready;
                if (owner_q) lsu_if.rvalid = mem_if.rvalid;
                else         ifu_if.rvalid = mem_if.rvalid;
            end
            default: ;
        endcase
    end

    assign arb_busy_o = (state_q != StIdle);
    assign arb_err_o  = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter; each task covers one scenario.
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, err;
    int   n_checks = 0;
    int   n_fail   = 0;

    axi_rd_arbiter_if ifu_bus ();
    axi_rd_arbiter_if lsu_bus ();
    axi_rd_arbiter_if mem_bus ();

    axi_rd_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ifu_if     (ifu_bus),
        .lsu_if     (lsu_bus),
        .mem_if     (mem_bus),
        .arb_busy_o (busy),
        .arb_err_o  (err)
    );

    always #5 clk = ~clk;

    // {ifu arready, lsu arready, mem arvalid, ifu rvalid, lsu rvalid, mem rready, busy, err}
    logic [7:0] flags;
    assign flags = {ifu_bus.arready, lsu_bus.arready, mem_bus.arvalid, ifu_bus.rvalid,
                    lsu_bus.rvalid, mem_bus.rready, busy, err};

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_inputs();
        ifu_bus.arvalid = 0; ifu_bus.arid = 0; ifu_bus.araddr = 0; ifu_bus.arlen = 0;
        ifu_bus.arsize = 3; ifu_bus.arburst = 1; ifu_bus.rready = 0;
        lsu_bus.arvalid = 0; lsu_bus.arid = 0; lsu_bus.araddr = 0; lsu_bus.arlen = 0;
        lsu_bus.arsize = 3; lsu_bus.arburst = 1; lsu_bus.rready = 0;
        mem_bus.arready = 0; mem_bus.rvalid = 0; mem_bus.rid = 0; mem_bus.rdata = 0;
        mem_bus.rresp = 0; mem_bus.rlast = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    task automatic ar_handshake(output logic [3:0] id);
        bit seen = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (mem_bus.arvalid === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ar_wait: mem arvalid never rose within 10 cycles, required 1");
            id = 'x;
        end else begin
            id = mem_bus.arid;
            mem_bus.arready = 1'b1;
            tick();
            mem_bus.arready = 1'b0;
        end
    endtask

    task automatic beat(input logic [3:0] rid, input logic [63:0] data, input logic last);
        bit seen = 0;
        mem_bus.rvalid = 1'b1; mem_bus.rid = rid; mem_bus.rdata = data; mem_bus.rlast = last;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (mem_bus.rready === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL r_wait: mem rready never rose within 10 cycles, required 1");
        end
        tick();
        mem_bus.rvalid = 1'b0; mem_bus.rlast = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_inputs();
        ifu_bus.arvalid = 1; lsu_bus.arvalid = 1; mem_bus.rvalid = 1; mem_bus.arready = 1;
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags got %b required 00000000", flags);
        end
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL reset_held_flags got %b required 00000000", flags);
        end
        clr_inputs();
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_spurious_rvalid();
        apply_reset();
        mem_bus.rvalid = 1; mem_bus.rlast = 1;
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL spurious_rready got %b required 00000000", flags);
        end
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0;
        #1;
        n_checks++;
        if (flags !== 8'b0000_0001) begin
            n_fail++; $display("FAIL spurious_err got %b required 00000001", flags);
        end
        apply_reset();
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL err_cleared got %b required 00000000", flags);
        end
    endtask

    task automatic test_single_ifu();
        ifu_bus.araddr = 32'h8000_0000; ifu_bus.arlen = 0; ifu_bus.arid = 3; ifu_bus.arvalid = 1;
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL ifu_idle got %b required 00000000", flags);
        end
        tick();
        n_checks++;
        if (flags !== 8'b0010_0010 || mem_bus.arid !== 4'd0 || mem_bus.araddr !== 32'h8000_0000)
        begin
            n_fail++;
            $display("FAIL ifu_ar got flags=%b arid=%0d addr=%h required 00100010 0 80000000",
                     flags, mem_bus.arid, mem_bus.araddr);
        end
        tick();
        n_checks++;
        if (flags !== 8'b0010_0010) begin
            n_fail++; $display("FAIL ifu_ar_wait got %b required 00100010", flags);
        end
        mem_bus.arready = 1;
        #1;
        n_checks++;
        if (flags !== 8'b1010_0010) begin
            n_fail++; $display("FAIL ifu_arready got %b required 10100010", flags);
        end
        tick();
        ifu_bus.arvalid = 0; mem_bus.arready = 0; ifu_bus.rready = 1;
        mem_bus.rvalid = 1; mem_bus.rlast = 1; mem_bus.rid = 0;
        mem_bus.rdata = 64'h1122_3344_5566_7788;
        #1;
        n_checks++;
        if (flags !== 8'b0001_0110 || ifu_bus.rid !== 4'd3 ||
            ifu_bus.rdata !== 64'h1122_3344_5566_7788) begin
            n_fail++;
            $display("FAIL ifu_r got flags=%b rid=%0d data=%h required 00010110 3 1122334455667788",
                     flags, ifu_bus.rid, ifu_bus.rdata);
        end
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0; ifu_bus.rready = 0;
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL ifu_done got %b required 00000000", flags);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] id;
        apply_reset();
        ifu_bus.arid = 2; ifu_bus.arvalid = 1; ifu_bus.rready = 1;
        lsu_bus.arid = 5; lsu_bus.arvalid = 1; lsu_bus.rready = 1;
        tick();
        n_checks++;
        if (flags !== 8'b0010_0010 || mem_bus.arid !== 4'd1) begin
            n_fail++;
            $display("FAIL tie_grant got flags=%b arid=%0d required 00100010 1", flags, mem_bus.arid);
        end
        mem_bus.arready = 1;
        #1;
        n_checks++;
        if (flags !== 8'b0110_0010) begin
            n_fail++; $display("FAIL tie_lsu_arready got %b required 01100010", flags);
        end
        tick();
        mem_bus.arready = 0; lsu_bus.arvalid = 0;
        mem_bus.rvalid = 1; mem_bus.rlast = 1; mem_bus.rid = 1; mem_bus.rdata = 64'hABCD;
        #1;
        n_checks++;
        if (flags !== 8'b0000_1110 || lsu_bus.rid !== 4'd5) begin
            n_fail++;
            $display("FAIL tie_lsu_r got flags=%b rid=%0d required 00001110 5", flags, lsu_bus.rid);
        end
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0;
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL tie_idle_gap got %b required 00000000", flags);
        end
        tick();
        n_checks++;
        if (flags !== 8'b0010_0010 || mem_bus.arid !== 4'd0) begin
            n_fail++;
            $display("FAIL tie_ifu_next got flags=%b arid=%0d required 00100010 0", flags, mem_bus.arid);
        end
        ar_handshake(id);
        ifu_bus.arvalid = 0;
        beat(4'd0, 64'h1, 1'b1);
        lsu_bus.rready = 0; ifu_bus.rready = 0;
    endtask

    task automatic test_lsu_burst();
        logic [3:0]  id;
        logic [63:0] got [4];
        int          k = 0;
        lsu_bus.arid = 7; lsu_bus.arlen = 3; lsu_bus.arvalid = 1;
        ar_handshake(id);
        lsu_bus.arvalid = 0;
        n_checks++;
        if (id !== 4'd1) begin
            n_fail++; $display("FAIL burst_arid got %0d required 1", id);
        end
        for (int c = 0; c < 40 && k < 4; c++) begin
            mem_bus.rvalid = (c % 3 != 1);
            mem_bus.rdata  = 64'h100 + 64'(k);
            mem_bus.rlast  = (k == 3);
            mem_bus.rid    = 1;
            lsu_bus.rready = (c % 2 == 0);
            #1;
            n_checks++;
            if ({lsu_bus.rvalid, mem_bus.rready} !== {mem_bus.rvalid, lsu_bus.rready}) begin
                n_fail++;
                $display("FAIL burst_pass c=%0d got rvalid=%b rready=%b required %b %b", c,
                         lsu_bus.rvalid, mem_bus.rready, mem_bus.rvalid, lsu_bus.rready);
            end
            if (mem_bus.rvalid && lsu_bus.rready) begin
                got[k] = lsu_bus.rdata;
                k++;
            end
            tick();
        end
        mem_bus.rvalid = 0; mem_bus.rlast = 0; lsu_bus.rready = 0;
        #1;
        n_checks++;
        if (k != 4 || got[0] !== 64'h100 || got[1] !== 64'h101 || got[2] !== 64'h102 ||
            got[3] !== 64'h103) begin
            n_fail++;
            $display("FAIL burst_data got %0d beats %h %h %h %h required 4 beats 100..103",
                     k, got[0], got[1], got[2], got[3]);
        end
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL burst_end got %b required 00000000", flags);
        end
    endtask

    task automatic test_len_mismatch();
        logic [3:0] id;
        lsu_bus.arid = 4; lsu_bus.arlen = 1; lsu_bus.arvalid = 1; lsu_bus.rready = 1;
        ar_handshake(id);
        lsu_bus.arvalid = 0;
        beat(4'd1, 64'h55, 1'b1);
        #1;
        n_checks++;
        if (flags !== 8'b0000_0001) begin
            n_fail++; $display("FAIL mismatch_err got %b required 00000001", flags);
        end
        lsu_bus.rready = 0;
        ifu_bus.arid = 9; ifu_bus.arlen = 0; ifu_bus.arvalid = 1; ifu_bus.rready = 1;
        ar_handshake(id);
        ifu_bus.arvalid = 0;
        n_checks++;
        if (id !== 4'd0) begin
            n_fail++; $display("FAIL mismatch_next_arid got %0d required 0", id);
        end
        mem_bus.rvalid = 1; mem_bus.rlast = 1; mem_bus.rid = 0; mem_bus.rdata = 64'hDEAD;
        #1;
        n_checks++;
        if (flags !== 8'b0001_0111 || ifu_bus.rid !== 4'd9 || ifu_bus.rdata !== 64'hDEAD) begin
            n_fail++;
            $display("FAIL mismatch_next_r got flags=%b rid=%0d data=%h required 00010111 9 dead",
                     flags, ifu_bus.rid, ifu_bus.rdata);
        end
        tick();
        mem_bus.rvalid = 0; mem_bus.rlast = 0; ifu_bus.rready = 0;
        #1;
        n_checks++;
        if (flags !== 8'b0000_0001) begin
            n_fail++; $display("FAIL mismatch_sticky got %b required 00000001", flags);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] id;
        apply_reset();
        ifu_bus.arid = 1; ifu_bus.arlen = 3; ifu_bus.arvalid = 1;
        ar_handshake(id);
        ifu_bus.arvalid = 0; ifu_bus.rready = 1;
        mem_bus.rvalid = 1; mem_bus.rid = 0; mem_bus.rlast = 0;
        #1;
        n_checks++;
        if (flags !== 8'b0001_0110) begin
            n_fail++; $display("FAIL areset_pre got %b required 00010110", flags);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL areset_immediate got %b required 00000000", flags);
        end
        clr_inputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ifu_bus.arid = 6; ifu_bus.arvalid = 1; ifu_bus.rready = 1;
        tick();
        n_checks++;
        if (flags !== 8'b0010_0010 || mem_bus.arid !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_regrant got flags=%b arid=%0d required 00100010 0",
                     flags, mem_bus.arid);
        end
        ar_handshake(id);
        ifu_bus.arvalid = 0;
        beat(4'd0, 64'h77, 1'b1);
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL areset_done got %b required 00000000", flags);
        end
        ifu_bus.rready = 0;
    endtask

    task automatic test_fairness();
        logic [3:0] id;
        logic [3:0] exp_id;
        apply_reset();
        ifu_bus.arvalid = 1; lsu_bus.arvalid = 1; ifu_bus.rready = 1; lsu_bus.rready = 1;
        for (int t = 0; t < 6; t++) begin
            exp_id = (t % 2 == 0) ? 4'd1 : 4'd0;
            ar_handshake(id);
            n_checks++;
            if (id !== exp_id) begin
                n_fail++; $display("FAIL fair_grant t=%0d got %0d required %0d", t, id, exp_id);
            end
            beat(exp_id, 64'(t), 1'b1);
        end
        clr_inputs();
        #1;
        n_checks++;
        if (flags !== 8'h00) begin
            n_fail++; $display("FAIL fair_end got %b required 00000000", flags);
        end
    endtask

    initial begin
        test_reset();
        test_spurious_rvalid();
        test_single_ifu();
        test_simultaneous();
        test_lsu_burst();
        test_len_mismatch();
        test_async_reset();
        test_fairness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares a single AXI4 read port (AR + R channels, 64-bit data) between the instruction-fetch master (IFU) and the load/store master (LSU).
- Sits between the IFU/LSU read interfaces and the memory-side AXI slave.
- Allows one outstanding read burst at a time.
- Uses round-robin arbitration and rewrites the transaction ID so returning data can be routed to its owner.
- Write channels (AW/W/B) are outside this block.

Parameters:
- ADDR_W, 32, address width of all AR channels
- DATA_W, 64, R data width
- ID_W, 4, AXI ID width on all ports

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- IFU_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  input  ID_W/ADDR_W/8/3/2/1  IFU read request
- IFU_AXI_ARREADY  output  1  IFU request accepted
- IFU_AXI_RID/RDATA/RRESP/RLAST/RVALID  output  ID_W/DATA_W/2/1/1  read data to IFU
- IFU_AXI_RREADY  input  1  IFU accepts beat
- LSU_AXI_*  (same set, same directions and widths as IFU_AXI_*)  LSU read interface
- MEM_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  output  ID_W/ADDR_W/8/3/2/1  request to memory
- MEM_AXI_ARREADY  input  1
- MEM_AXI_RID/RDATA/RRESP/RLAST/RVALID  input  ID_W/DATA_W/2/1/1  data from memory
- MEM_AXI_RREADY  output  1
- arb_busy  output  1  state != IDLE
- arb_err  output  1  sticky protocol error

Behaviour:
- State machine (registered):
  - IDLE: no grant.
  - AR: forward the owner's AR channel to memory.
  - R: forward the R channel to the owner.
- Registers: owner (0=IFU, 1=LSU), last (previous owner), len_q (latched ARLEN), beat counter cnt (8 bit), orig_id (owner's ARID).
- Reset (rst low, takes effect immediately, no clock needed):
  - state=IDLE, owner=0, last=0, cnt=0, arb_err=0.
  - All VALID/READY outputs = 0 while rst is low.
- IDLE arbitration:
  - Only one ARVALID high: grant that master.
  - Both high: grant the master != last. LSU wins the first tie after reset.
  - On grant: owner<=winner, last<=winner, state<=AR.
  - IDLE emits no MEM_AXI_ARVALID. This gives 1 cycle of grant latency from ARVALID to MEM_AXI_ARVALID.
- AR:
  - MEM_AXI_AR* = owner's AR fields, except MEM_AXI_ARID = {ID_W-1 zeros, owner}.
  - Owner ARREADY = MEM_AXI_ARREADY. Non-owner ARREADY = 0.
  - On MEM ARVALID&ARREADY: latch len_q=ARLEN and orig_id=owner ARID, cnt<=0, state<=R.
  - A master must hold its AR fields stable while ARVALID is high; the arbiter does not buffer AR.
- R:
  - Owner R* = MEM R*, except owner RID = orig_id. Non-owner RVALID = 0.
  - MEM_AXI_RREADY = owner RREADY. Combinational passthrough, zero added latency.
  - Each beat (MEM RVALID&RREADY): cnt<=cnt+1.
  - Beat with RLAST=1: state<=IDLE.
  - The new arbitration happens in the following IDLE cycle. Back-to-back bursts therefore have one idle cycle between them.
- Error detection (arb_err set and held until reset, routing unaffected):
  - RLAST on a beat where cnt != len_q.
  - No RLAST on the beat where cnt == len_q.
  - MEM_AXI_RID[0] != owner on any beat.
- MEM_AXI_RVALID in IDLE or AR: ignored. MEM_AXI_RREADY = 0 in those states. Sets arb_err.
- Requester drops ARVALID in AR before the handshake: MEM_AXI_ARVALID follows it low. The arbiter stays in AR with the grant held; it does not re-arbitrate.
- Reset asserted mid-burst: immediate return to IDLE. The in-flight memory burst is abandoned; the environment resets memory together with this block.
- arb_busy = (state != IDLE), registered state decode.

Test Plan:
- Single IFU read:
  - Stimulus: IFU ARADDR=0x8000_0000, ARLEN=0, ARID=3. Memory ARREADY after 2 cycles, returns RDATA=0x1122334455667788 with RLAST.
  - Required: MEM ARVALID rises 1 cycle after IFU ARVALID. MEM ARID=0. IFU receives data with RID=3. LSU RVALID stays 0.
- Simultaneous requests after reset:
  - Stimulus: IFU and LSU ARVALID high in the same cycle.
  - Required: LSU granted first (MEM ARID=1). After its RLAST, one IDLE cycle, then IFU granted (MEM ARID=0).
- LSU burst:
  - Stimulus: ARLEN=3, memory inserts RVALID gaps, LSU RREADY toggles.
  - Required: 4 beats delivered in order. State returns to IDLE after the 4th beat. arb_err=0.
- Length mismatch:
  - Stimulus: ARLEN=1, memory asserts RLAST on beat 0.
  - Required: arb_err=1 and stays 1. State returns to IDLE. The next IFU read completes normally.
- Async reset mid-burst:
  - Stimulus: drop rst between clock edges during R state.
  - Required: arb_busy, all RVALID and ARVALID outputs go 0 without a clock edge. After release, a new IFU read is granted normally.
- Fairness:
  - Stimulus: both masters request continuously for 6 transactions.
  - Required: grants alternate LSU, IFU, LSU, IFU, LSU, IFU.
